filtro_sensores: RTL and testbench

Input-conditioning stage sitting directly upstream of the irrigation controller: it receives the raw field signals (tank level switches A/M/B, soil humidity US, air humidity UA, temperature T, display select SL) and delivers synchronized, debounced copies that drive the controller's inputs one-for-one. It also checks the tank level switches for a physically impossible combination and raises ERR when a sensor fault persists. While ERR is asserted, it freezes the level outputs at the last plausible value so the alarm and valve logic never acts on garbage.

---
 rtl/filtro_pkg.sv | 16 +
 rtl/debounce_canal.sv | 50 +++++
 rtl/filtro_sensores.sv | 137 +++++++++++++
 tb/tb_filtro_sensores.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/filtro_pkg.sv
// rtl/filtro_pkg.sv - fault-state encoding and level-switch plausibility for filtro_sensores
package filtro_pkg;

  typedef enum logic [1:0] {
    ST_OK      = 2'd0,
    ST_SUSPECT = 2'd1,
    ST_FAULT   = 2'd2,
    ST_RECOVER = 2'd3
  } estado_t;

  // A wet switch above a dry one cannot happen in a real tank.
  function automatic logic nivel_valido(input logic a, input logic m, input logic b);
    return (!a || m) && (!m || b);
  endfunction

endpackage

// File: rtl/debounce_canal.sv
// rtl/debounce_canal.sv - two-flop synchronizer plus debounce counter for one raw input
module debounce_canal #(
  parameter int DEB_CYCLES = 1000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic dout_next
);

  localparam int CW = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DEB_CYCLES - 1);

  logic          sync1_q, sync1_d;
  logic          sync2_q, sync2_d;
  logic          stable_q, stable_d;
  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    sync1_d  = din;
    sync2_d  = sync1_q;
    stable_d = stable_q;
    cnt_d    = '0;
    if (sync2_q != stable_q) begin
      if (cnt_q == CNT_LAST) begin
        stable_d = sync2_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q  <= 1'b0;
      sync2_q  <= 1'b0;
      stable_q <= 1'b0;
      cnt_q    <= '0;
    end else begin
      sync1_q  <= sync1_d;
      sync2_q  <= sync2_d;
      stable_q <= stable_d;
      cnt_q    <= cnt_d;
    end
  end

  // Exposing the next value lets the top register its outputs on the commit edge.
  assign dout_next = stable_d;

endmodule

// File: rtl/filtro_sensores.sv
// rtl/filtro_sensores.sv - debounced sensor conditioning with tank-level fault freeze
// SL_TOGGLE_EN: SL_RAW becomes a push-button and SL toggles on each debounced press.
module filtro_sensores
  import filtro_pkg::*;
#(
  parameter int DEB_CYCLES   = 1000,
  parameter int FAULT_CYCLES = 4000
) (
  input  logic CLK,
  input  logic RST_N,
  input  logic A_RAW,
  input  logic M_RAW,
  input  logic B_RAW,
  input  logic US_RAW,
  input  logic UA_RAW,
  input  logic T_RAW,
  input  logic SL_RAW,
  output logic A,
  output logic M,
  output logic B,
  output logic US,
  output logic UA,
  output logic T,
  output logic SL,
  output logic ERR,
  output logic VLD
);

  localparam int VW = $clog2(DEB_CYCLES + 2);
  localparam int FW = $clog2(FAULT_CYCLES + 1);
  localparam logic [VW-1:0] VLD_LAST = VW'(DEB_CYCLES + 1);
  localparam logic [FW-1:0] FCNT_LIM = FW'(FAULT_CYCLES);

  logic [6:0] raw;
  logic [6:0] deb_d;

  assign raw = {A_RAW, M_RAW, B_RAW, US_RAW, UA_RAW, T_RAW, SL_RAW};

  for (genvar i = 0; i < 7; i++) begin : g_canal
    debounce_canal #(.DEB_CYCLES(DEB_CYCLES)) u_canal (
      .clk       (CLK),
      .rst_n     (RST_N),
      .din       (raw[i]),
      .dout_next (deb_d[i])
    );
  end

  estado_t       state_q, state_d;
  logic [FW-1:0] fcnt_q, fcnt_d;
  logic [VW-1:0] st_cnt_q, st_cnt_d;
  logic          vld_q, vld_d;
  logic [2:0]    last_good_q, last_good_d;
  logic [2:0]    amb_q, amb_d;
  logic [2:0]    lvl_q, lvl_d;
  logic          sl_q, sl_d;
  logic          pat_ok;

  always_comb begin
    pat_ok  = nivel_valido(deb_d[6], deb_d[5], deb_d[4]);
    state_d = state_q;
    fcnt_d  = '0;
    case (state_q)
      ST_OK: begin
        if (!pat_ok) state_d = ST_SUSPECT;
      end
      ST_SUSPECT: begin
        if (pat_ok)                  state_d = ST_OK;
        else if (fcnt_q == FCNT_LIM) state_d = ST_FAULT;
        else                         fcnt_d  = fcnt_q + 1'b1;
      end
      ST_FAULT: begin
        if (pat_ok) state_d = ST_RECOVER;
      end
      ST_RECOVER: begin
        if (!pat_ok)                 state_d = ST_FAULT;
        else if (fcnt_q == FCNT_LIM) state_d = ST_OK;
        else                         fcnt_d  = fcnt_q + 1'b1;
      end
      default: state_d = ST_OK;
    endcase

    // Output mux keys off next state so an invalid pattern is never driven.
    last_good_d = pat_ok ? deb_d[6:4] : last_good_q;
    amb_d       = (state_d == ST_OK) ? deb_d[6:4] : last_good_d;
    lvl_d       = deb_d[3:1];

    vld_d    = vld_q | (st_cnt_q == VLD_LAST);
    st_cnt_d = vld_q ? st_cnt_q : st_cnt_q + 1'b1;
  end

`ifdef SL_TOGGLE_EN
  logic sl_deb_q, sl_deb_d;

  always_comb begin
    sl_deb_d = deb_d[0];
    sl_d     = sl_q ^ (deb_d[0] & ~sl_deb_q);
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) sl_deb_q <= 1'b0;
    else        sl_deb_q <= sl_deb_d;
  end
`else
  always_comb begin
    sl_d = deb_d[0];
  end
`endif

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q     <= ST_OK;
      fcnt_q      <= '0;
      st_cnt_q    <= '0;
      vld_q       <= 1'b0;
      last_good_q <= 3'b000;
      amb_q       <= 3'b000;
      lvl_q       <= 3'b000;
      sl_q        <= 1'b0;
    end else begin
      state_q     <= state_d;
      fcnt_q      <= fcnt_d;
      st_cnt_q    <= st_cnt_d;
      vld_q       <= vld_d;
      last_good_q <= last_good_d;
      amb_q       <= amb_d;
      lvl_q       <= lvl_d;
      sl_q        <= sl_d;
    end
  end

  assign {A, M, B}   = amb_q;
  assign {US, UA, T} = lvl_q;
  assign SL          = sl_q;
  assign VLD         = vld_q;
  assign ERR         = (state_q == ST_FAULT) || (state_q == ST_RECOVER);

endmodule

// File: tb/tb_filtro_sensores.sv
// tb/tb_filtro_sensores.sv - scoreboard bench for filtro_sensores (DEB_CYCLES=4, FAULT_CYCLES=8)
module tb_filtro_sensores;

  localparam int DEB = 4;
  localparam int FLT = 8;
`ifdef SL_TOGGLE_EN
  localparam logic SL_BASE = 1'b1;
`else
  localparam logic SL_BASE = 1'b0;
`endif

  localparam logic [8:0] M_ALL = 9'h1ff;
  localparam logic [8:0] M_ERR = 9'h080;
  localparam logic [8:0] M_AMB = 9'h070;
  localparam logic [8:0] M_EA  = 9'h0f0;
  localparam logic [8:0] M_UU  = 9'h00c;
  localparam logic [8:0] M_T   = 9'h002;
  localparam logic [8:0] M_SL  = 9'h001;

  logic CLK = 1'b0;
  logic RST_N = 1'b0;
  logic A_RAW = 1'b0, M_RAW = 1'b0, B_RAW = 1'b0;
  logic US_RAW = 1'b0, UA_RAW = 1'b0, T_RAW = 1'b0, SL_RAW = 1'b0;
  logic A, M, B, US, UA, T, SL, ERR, VLD;
  logic [8:0] outs;

  assign outs = {VLD, ERR, A, M, B, US, UA, T, SL};

  filtro_sensores #(.DEB_CYCLES(DEB), .FAULT_CYCLES(FLT)) dut (
    .CLK(CLK), .RST_N(RST_N),
    .A_RAW(A_RAW), .M_RAW(M_RAW), .B_RAW(B_RAW),
    .US_RAW(US_RAW), .UA_RAW(UA_RAW), .T_RAW(T_RAW), .SL_RAW(SL_RAW),
    .A(A), .M(M), .B(B), .US(US), .UA(UA), .T(T), .SL(SL),
    .ERR(ERR), .VLD(VLD)
  );

  always #5 CLK = ~CLK;

  int edge_n = 0;
  always @(posedge CLK) edge_n <= edge_n + 1;

  int checks = 0;
  int errors = 0;

  typedef struct {
    int         at;
    logic [8:0] mask;
    logic [8:0] exp;
    string      nm;
  } exp_t;

  exp_t sb[$];
  exp_t cur;

  task automatic sb_push(input int at, input logic [8:0] mask, input logic [8:0] exp,
                         input string nm);
    exp_t e;
    int   i;
    e.at = at; e.mask = mask; e.exp = exp; e.nm = nm;
    i = 0;
    while (i < sb.size() && sb[i].at <= at) i++;
    sb.insert(i, e);
  endtask

  // Expectations fall due on an edge and are compared half a cycle later.
  always @(negedge CLK) begin
    while (sb.size() > 0 && sb[0].at <= edge_n) begin
      cur = sb.pop_front();
      checks++;
      if (cur.at != edge_n) begin
        errors++;
        $display("FAIL %s: due at edge %0d, got checked at %0d required on time", cur.nm, cur.at, edge_n);
      end else if ((outs & cur.mask) !== (cur.exp & cur.mask)) begin
        errors++;
        $display("FAIL %s @edge %0d: got %b required %b (mask %b)", cur.nm, edge_n,
                 outs & cur.mask, cur.exp & cur.mask, cur.mask);
      end
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge CLK);
      #1;
    end
  endtask

  task automatic test_reset();
    int r;
    RST_N = 1'b0;
    {A_RAW, M_RAW, B_RAW, US_RAW, UA_RAW, T_RAW, SL_RAW} = 7'h7f;
    step(3);
    checks++;
    if (outs !== 9'h000) begin
      errors++;
      $display("FAIL reset_hold: got %b required %b", outs, 9'h000);
    end
    @(negedge CLK);
    RST_N = 1'b1;
    r = edge_n;
    sb_push(r + DEB + 1, M_ALL, 9'h000, "startup_pre");
    sb_push(r + DEB + 2, M_ALL, 9'h17f, "startup_valid");
    step(8);
  endtask

  task automatic test_base();
    int p;
    p = edge_n;
    {A_RAW, M_RAW, B_RAW} = 3'b011;
    {US_RAW, UA_RAW, T_RAW, SL_RAW} = 4'b0000;
    sb_push(p + 5, M_ALL, 9'h17f, "base_pre");
    sb_push(p + 6, M_ALL, {1'b1, 1'b0, 3'b011, 3'b000, SL_BASE}, "base_set");
    step(8);
  endtask

  task automatic test_glitch();
    int p;
    p = edge_n;
    for (int i = 1; i <= 24; i++) sb_push(p + i, M_T, 9'h000, "t_glitch_blocked");
    repeat (3) begin
      T_RAW = 1'b1;
      step(DEB - 1);
      T_RAW = 1'b0;
      step(3);
    end
    step(6);
    p = edge_n;
    T_RAW = 1'b1;
    sb_push(p + 5, M_T, 9'h000, "t_pulse_pre");
    sb_push(p + 6, M_T, 9'h002, "t_pulse_rise");
    sb_push(p + 9, M_T, 9'h002, "t_pulse_hold");
    sb_push(p + 10, M_T, 9'h000, "t_pulse_fall");
    step(DEB);
    T_RAW = 1'b0;
    step(8);
    checks++;
    if (T !== 1'b0) begin
      errors++;
      $display("FAIL t_final: got %b required 0", T);
    end
  endtask

  task automatic test_multi();
    int p;
    p = edge_n;
    US_RAW = 1'b1;
    UA_RAW = 1'b1;
    sb_push(p + 5, M_UU, 9'h000, "us_ua_pre");
    sb_push(p + 6, M_UU, 9'h00c, "us_ua_together");
    step(8);
  endtask

  task automatic test_fault();
    int p;
    p = edge_n;
    A_RAW = 1'b1;
    M_RAW = 1'b0;
    for (int i = 1; i <= 20; i++) sb_push(p + i, M_AMB, 9'h030, "amb_frozen_011");
    sb_push(p + 6 + FLT, M_ERR, 9'h000, "err_pre");
    sb_push(p + 7 + FLT, M_ERR, 9'h080, "err_rise");
    step(20);
    checks++;
    if (ERR !== 1'b1 || {A, M, B} !== 3'b011) begin
      errors++;
      $display("FAIL fault_state: got err=%b amb=%b required err=1 amb=011", ERR, {A, M, B});
    end
  endtask

  task automatic test_recover();
    int q;
    int r;
    q = edge_n;
    M_RAW = 1'b1;
    for (int i = 1; i <= 20; i++) sb_push(q + i, M_ERR, 9'h080, "err_held_short_recover");
    sb_push(q + 8, M_AMB, 9'h070, "amb_recover_111");
    sb_push(q + 16, M_AMB, 9'h070, "amb_refault_111");
    step(5);
    M_RAW = 1'b0;
    step(7);
    r = edge_n;
    M_RAW = 1'b1;
    sb_push(r + 6 + FLT, M_ERR, 9'h080, "err_before_clear");
    sb_push(r + 7 + FLT, M_EA, 9'h070, "err_clear_amb_111");
    step(18);
    checks++;
    if (ERR !== 1'b0) begin
      errors++;
      $display("FAIL recover_final: got err=%b required 0", ERR);
    end
  endtask

  task automatic test_short_invalid();
    int p;
    p = edge_n;
    M_RAW = 1'b0;
    for (int i = 1; i <= 22; i++) sb_push(p + i, M_EA, 9'h070, "short_invalid_no_err");
    step(6);
    M_RAW = 1'b1;
    step(16);
    p = edge_n;
    A_RAW = 1'b0;
    sb_push(p + 5, M_EA, 9'h070, "ok_follow_pre");
    sb_push(p + 6, M_EA, 9'h030, "ok_follow_011");
    step(8);
    checks++;
    if (ERR !== 1'b0) begin
      errors++;
      $display("FAIL short_final: got err=%b required 0", ERR);
    end
  endtask

`ifdef SL_TOGGLE_EN
  task automatic test_sl_toggle();
    int p;
    p = edge_n;
    SL_RAW = 1'b1;
    sb_push(p + 5, M_SL, 9'h001, "sl_press1_pre");
    sb_push(p + 6, M_SL, 9'h000, "sl_press1_toggle");
    sb_push(p + 20, M_SL, 9'h000, "sl_release_hold");
    sb_push(p + 25, M_SL, 9'h000, "sl_bounce_ignored");
    sb_push(p + 35, M_SL, 9'h000, "sl_press2_pre");
    sb_push(p + 36, M_SL, 9'h001, "sl_press2_toggle");
    step(10);
    SL_RAW = 1'b0;
    step(10);
    SL_RAW = 1'b1;
    step(2);
    SL_RAW = 1'b0;
    step(8);
    SL_RAW = 1'b1;
    step(10);
    SL_RAW = 1'b0;
    sb_push(edge_n + 10, M_SL, 9'h001, "sl_release2_hold");
    step(10);
  endtask
`endif

  task automatic test_async_reset();
    for (int i = 0; i < 100 && sb.size() > 0; i++) step(1);
    @(posedge CLK);
    #2;
    RST_N = 1'b0;
    #1;
    checks++;
    if (outs !== 9'h000) begin
      errors++;
      $display("FAIL async_reset: got %b required %b", outs, 9'h000);
    end
    step(2);
    RST_N = 1'b1;
    step(2);
  endtask

  initial begin
    test_reset();
    test_base();
    test_glitch();
    test_multi();
    test_fault();
    test_recover();
    test_short_invalid();
`ifdef SL_TOGGLE_EN
    test_sl_toggle();
`endif
    test_async_reset();
    while (sb.size() > 0) begin
      cur = sb.pop_front();
      checks++;
      errors++;
      $display("FAIL %s: expectation for edge %0d got no sample required one", cur.nm, cur.at);
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got still running required finished");
    $fatal(1);
  end

endmodule
